hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RV64 core, replacing the purely combinational stall/flush glue between the pipeline registers.
- Adds load-use and RAW interlocks, EX-stage forwarding selects and bus-wait stalling.
- Adds a registered redirect buffer that holds a taken branch until the fetch stage can accept it.
- Sits beside the pipeline and drives every stage's stall and flush.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_fwd_sel.sv | 28 ++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encodings and the redirect buffer state.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_HOLD = 1'b1
  } redir_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand EX forwarding selector: the MEM result wins over the WB
// result, and x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              we_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              we_wb,
  output logic [1:0]        sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = we_mem && (rd_mem != '0) && (rs == rd_mem);
  assign wb_hit  = we_wb  && (rd_wb  != '0) && (rs == rd_wb);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/RAW interlocks, EX forwarding selects,
// bus-wait stalling and a one-entry redirect buffer toward IF.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RD_IDLE | no pending redirect; a taken branch passes straight to IF
// RD_HOLD | redirect parked in pend_pc until IF signals if_ready
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rs1_EX,
  input  logic [REG_AW-1:0] rs2_EX,
  input  logic [REG_AW-1:0] rd_EX,
  input  logic              regwrite_EX,
  input  logic              memread_EX,
  input  logic [REG_AW-1:0] rd_MEM,
  input  logic              regwrite_MEM,
  input  logic [REG_AW-1:0] rd_WB,
  input  logic              regwrite_WB,
  input  logic              branch_taken_EX,
  input  logic [XLEN-1:0]   branch_target_EX,
  input  logic              mem_req_MEM,
  input  logic              mem_ready,
  input  logic              if_ready,
  output logic              stall_IF,
  output logic              stall_ID,
  output logic              stall_EX,
  output logic              stall_MEM,
  output logic              flush_ID,
  output logic              flush_EX,
  output logic              branch_taken_IF,
  output logic [XLEN-1:0]   branch_target_IF,
  output logic [1:0]        fwd_a_EX,
  output logic [1:0]        fwd_b_EX
);

  function automatic logic hit(input logic [REG_AW-1:0] r,
                               input logic [REG_AW-1:0] rd,
                               input logic              we);
    return we && (rd != '0) && (r == rd);
  endfunction

  redir_state_e    state_q, state_nxt;
  logic [XLEN-1:0] pend_pc_q, pend_pc_nxt;

  logic bus_busy;
  logic take;
  logic hit_ex;
  logic hit_mem;
  logic load_use;
  logic data_stall;
  logic hold;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  assign bus_busy = mem_req_MEM & ~mem_ready;
  assign take     = branch_taken_EX & ~bus_busy;

  assign hit_ex   = hit(rs1_ID, rd_EX, regwrite_EX)   | hit(rs2_ID, rd_EX, regwrite_EX);
  assign hit_mem  = hit(rs1_ID, rd_MEM, regwrite_MEM) | hit(rs2_ID, rd_MEM, regwrite_MEM);
  assign load_use = memread_EX & hit_ex;

  // WB is excluded: the regfile writes through, so ID already sees the value.
  assign data_stall = FWD_EN ? load_use : (load_use | hit_ex | hit_mem);

  assign hold = (state_q == RD_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RD_IDLE;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_nxt;
      pend_pc_q <= pend_pc_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    pend_pc_nxt = pend_pc_q;
    case (state_q)
      RD_IDLE: begin
        if (take && !if_ready) begin
          state_nxt   = RD_HOLD;
          pend_pc_nxt = branch_target_EX;
        end
      end
      RD_HOLD: begin
        // A newer taken branch here should be impossible; keep the newest
        // target so IF is at least steered to the latest resolution.
        if (take) begin
          pend_pc_nxt = branch_target_EX;
        end else if (if_ready) begin
          state_nxt = RD_IDLE;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  assign stall_MEM = bus_busy;
  assign stall_EX  = bus_busy;
  assign stall_ID  = bus_busy | (data_stall & ~take);
  assign stall_IF  = stall_ID | hold;
  assign flush_ID  = take | hold;
  assign flush_EX  = take | (data_stall & ~bus_busy);

  assign branch_taken_IF  = take | hold;
  assign branch_target_IF = hold ? pend_pc_q : branch_target_EX;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs     (rs1_EX),
    .rd_mem (rd_MEM),
    .we_mem (regwrite_MEM),
    .rd_wb  (rd_WB),
    .we_wb  (regwrite_WB),
    .sel    (sel_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs     (rs2_EX),
    .rd_mem (rd_MEM),
    .we_mem (regwrite_MEM),
    .rd_wb  (rd_WB),
    .we_wb  (regwrite_WB),
    .sel    (sel_b)
  );

  assign fwd_a_EX = FWD_EN ? sel_a : FWD_RF;
  assign fwd_b_EX = FWD_EN ? sel_b : FWD_RF;

  a_no_take_in_hold : assert property (
    @(posedge clk) disable iff (!rst_n) !(hold && take)
  ) else $error("hazard_ctrl: taken branch while redirect already pending");

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one forwarding-mode and one interlock-mode
// instance share stimulus; expected values are hand-computed per vector.
module tb_hazard_ctrl;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic              regwrite_EX, memread_EX, regwrite_MEM, regwrite_WB;
  logic              branch_taken_EX, mem_req_MEM, mem_ready, if_ready;
  logic [XLEN-1:0]   branch_target_EX;

  logic            s_if_f, s_id_f, s_ex_f, s_mem_f, f_id_f, f_ex_f, bt_f;
  logic [XLEN-1:0] tgt_f;
  logic [1:0]      fa_f, fb_f;
  logic            s_if_i, s_id_i, s_ex_i, s_mem_i, f_id_i, f_ex_i, bt_i;
  logic [XLEN-1:0] tgt_i;
  logic [1:0]      fa_i, fb_i;

  // {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, branch_taken_IF}
  logic [6:0] ctl_f, ctl_i;
  assign ctl_f = {s_if_f, s_id_f, s_ex_f, s_mem_f, f_id_f, f_ex_f, bt_f};
  assign ctl_i = {s_if_i, s_id_i, s_ex_i, s_mem_i, f_id_i, f_ex_i, bt_i};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(1'b1)) dut_fwd (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
    .rd_EX(rd_EX), .regwrite_EX(regwrite_EX), .memread_EX(memread_EX),
    .rd_MEM(rd_MEM), .regwrite_MEM(regwrite_MEM),
    .rd_WB(rd_WB), .regwrite_WB(regwrite_WB),
    .branch_taken_EX(branch_taken_EX), .branch_target_EX(branch_target_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready), .if_ready(if_ready),
    .stall_IF(s_if_f), .stall_ID(s_id_f), .stall_EX(s_ex_f), .stall_MEM(s_mem_f),
    .flush_ID(f_id_f), .flush_EX(f_ex_f),
    .branch_taken_IF(bt_f), .branch_target_IF(tgt_f),
    .fwd_a_EX(fa_f), .fwd_b_EX(fb_f)
  );

  hazard_ctrl #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(1'b0)) dut_ilk (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
    .rd_EX(rd_EX), .regwrite_EX(regwrite_EX), .memread_EX(memread_EX),
    .rd_MEM(rd_MEM), .regwrite_MEM(regwrite_MEM),
    .rd_WB(rd_WB), .regwrite_WB(regwrite_WB),
    .branch_taken_EX(branch_taken_EX), .branch_target_EX(branch_target_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready), .if_ready(if_ready),
    .stall_IF(s_if_i), .stall_ID(s_id_i), .stall_EX(s_ex_i), .stall_MEM(s_mem_i),
    .flush_ID(f_id_i), .flush_EX(f_ex_i),
    .branch_taken_IF(bt_i), .branch_target_IF(tgt_i),
    .fwd_a_EX(fa_i), .fwd_b_EX(fb_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    rs1_ID = '0; rs2_ID = '0; rs1_EX = '0; rs2_EX = '0;
    rd_EX = '0; rd_MEM = '0; rd_WB = '0;
    regwrite_EX = 1'b0; memread_EX = 1'b0; regwrite_MEM = 1'b0; regwrite_WB = 1'b0;
    branch_taken_EX = 1'b0; branch_target_EX = '0;
    mem_req_MEM = 1'b0; mem_ready = 1'b0; if_ready = 1'b0;
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the
  // falling edge, well away from the state update.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    next_cyc();

    // reset: all-zero inputs give all-zero outputs
    sample();
    chk("rst_ctl", ctl_f, 7'b0000000);
    chk("rst_fwd", {fa_f, fb_f}, 4'b0000);
    chk("rst_tgt", tgt_f, 64'h0);

    // load-use: ld x5 in EX, rs1_ID=5
    next_cyc();
    memread_EX = 1'b1; regwrite_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5;
    sample();
    chk("lu_ctl", ctl_f, 7'b1100010);
    // load moves to MEM, dependent instruction now in EX
    next_cyc();
    clr_inputs();
    rd_MEM = 5'd5; regwrite_MEM = 1'b1; rs1_EX = 5'd5;
    sample();
    chk("lu_next_ctl", ctl_f, 7'b0000000);
    chk("lu_next_fwd", {fa_f, fb_f}, 4'b1000);
    chk("lu_next_fwd_ilk", {fa_i, fb_i}, 4'b0000);

    // double forward: MEM beats WB
    next_cyc();
    clr_inputs();
    rd_MEM = 5'd7; regwrite_MEM = 1'b1; rd_WB = 5'd7; regwrite_WB = 1'b1; rs2_EX = 5'd7;
    sample();
    chk("dbl_fwd", {fa_f, fb_f}, 4'b0010);
    next_cyc();
    rd_MEM = 5'd0; rd_WB = 5'd0; rs2_EX = 5'd0;
    sample();
    chk("x0_fwd", {fa_f, fb_f}, 4'b0000);
    next_cyc();
    rd_MEM = 5'd9; rd_WB = 5'd7; rs2_EX = 5'd7; rs1_EX = 5'd7;
    sample();
    chk("wb_fwd", {fa_f, fb_f}, 4'b0101);

    // interlock mode: add writing x3 in MEM, rs2_ID=3
    next_cyc();
    clr_inputs();
    rd_MEM = 5'd3; regwrite_MEM = 1'b1; rs2_ID = 5'd3;
    sample();
    chk("ilk_mem_ctl", ctl_i, 7'b1100010);
    chk("ilk_mem_ctl_fwdmode", ctl_f, 7'b0000000);
    next_cyc();
    clr_inputs();
    rd_WB = 5'd3; regwrite_WB = 1'b1; rs2_ID = 5'd3;
    sample();
    chk("ilk_wb_ctl", ctl_i, 7'b0000000);
    next_cyc();
    clr_inputs();
    rd_EX = 5'd3; regwrite_EX = 1'b1; rs1_ID = 5'd3;
    sample();
    chk("ilk_ex_ctl", ctl_i, 7'b1100010);
    chk("ilk_ex_ctl_fwdmode", ctl_f, 7'b0000000);

    // straight-through redirect
    next_cyc();
    clr_inputs();
    branch_taken_EX = 1'b1; branch_target_EX = 64'h0000_0000_0000_1230; if_ready = 1'b1;
    sample();
    chk("pass_ctl", ctl_f, 7'b0000111);
    chk("pass_tgt", tgt_f, 64'h0000_0000_0000_1230);
    next_cyc();
    clr_inputs();
    sample();
    chk("pass_after_ctl", ctl_f, 7'b0000000);

    // redirect hold: if_ready low 3 cycles
    next_cyc();
    branch_taken_EX = 1'b1; branch_target_EX = 64'h0000_0000_8000_0040;
    sample();
    chk("hold_c0_ctl", ctl_f, 7'b0000111);
    chk("hold_c0_tgt", tgt_f, 64'h0000_0000_8000_0040);
    for (int c = 1; c <= 3; c++) begin
      next_cyc();
      branch_taken_EX = 1'b0;
      branch_target_EX = 64'hdead_0000_0000_1234;
      if_ready = (c == 3);
      sample();
      chk($sformatf("hold_c%0d_ctl", c), ctl_f, 7'b1000101);
      chk($sformatf("hold_c%0d_tgt", c), tgt_f, 64'h0000_0000_8000_0040);
    end
    next_cyc();
    clr_inputs();
    sample();
    chk("hold_done_ctl", ctl_f, 7'b0000000);

    // branch beats a load-use stall
    next_cyc();
    memread_EX = 1'b1; regwrite_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5;
    branch_taken_EX = 1'b1; branch_target_EX = 64'h40; if_ready = 1'b1;
    sample();
    chk("br_over_lu_ctl", ctl_f, 7'b0000111);

    // bus wait with a branch in EX
    next_cyc();
    clr_inputs();
    mem_req_MEM = 1'b1; branch_taken_EX = 1'b1; branch_target_EX = 64'h100; if_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sample();
      chk($sformatf("bus_c%0d_ctl", c), ctl_f, 7'b1111000);
      next_cyc();
    end
    mem_ready = 1'b1;
    sample();
    chk("bus_free_ctl", ctl_f, 7'b0000111);
    chk("bus_free_tgt", tgt_f, 64'h100);

    // bus wait suppresses the load-use bubble
    next_cyc();
    clr_inputs();
    mem_req_MEM = 1'b1;
    memread_EX = 1'b1; regwrite_EX = 1'b1; rd_EX = 5'd5; rs2_ID = 5'd5;
    sample();
    chk("bus_lu_ctl", ctl_f, 7'b1111000);

    // reset while holding a redirect
    next_cyc();
    clr_inputs();
    branch_taken_EX = 1'b1; branch_target_EX = 64'h200;
    next_cyc();
    clr_inputs();
    sample();
    chk("rst_hold_pre_bt", bt_f, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hold_bt", bt_f, 1'b0);
    chk("rst_hold_ctl", ctl_f, 7'b0000000);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    sample();
    chk("rst_release_ctl", ctl_f, 7'b0000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, want completion");
    $fatal(1, "timeout");
  end

endmodule
